// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I width
// encodings and the word-address mask.
package lsu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRmwRd,
    StWrite,
    StDone
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
// Halfword lanes use offset[1] only, so addr[0] is ignored for halfwords.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  function automatic logic [31:0] lane_extract(logic [31:0] rd, logic [1:0] off, logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_W:    return rd;
      F3_BU:   return {24'b0, b};
      F3_HU:   return {16'b0, h};
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(logic [31:0] rd, logic [15:0] wd, logic [1:0] off,
                                             logic [2:0] f3);
    logic [31:0] m;
    m = rd;
    case (f3)
      F3_B: m[{off, 3'b000} +: 8] = wd[7:0];
      F3_H: begin
        if (off[1]) m[31:16] = wd;
        else        m[15:0]  = wd;
      end
      default: ;
    endcase
    return m;
  endfunction

  assign load_val = lane_extract(rdata, offset, funct3);
  assign merged   = lane_merge(rdata, wdata, offset, funct3);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sequences word-only memory accesses for RV32I loads/stores.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [DATA_W-1:0] load_data,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic [15:0]       sdata_q;
  logic [DATA_W-1:0] wbuf_q;
  logic [DATA_W-1:0] load_data_q;
  logic              fault_q;

  logic              accept;
  logic              req_illegal;
  logic              req_misalign;
  logic              req_fault;
  logic [31:0]       extract_val;
  logic [31:0]       merge_val;

  assign accept = (state_q == StIdle) && start && (is_load || is_store);

  always_comb begin
    req_illegal  = 1'b0;
    req_misalign = 1'b0;
    if (is_load) req_illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    else         req_illegal = !(funct3 inside {F3_B, F3_H, F3_W});
`ifdef LSU_MISALIGN_TRAP_EN
    if ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) req_misalign = 1'b1;
    if (funct3 == F3_W && addr[1:0] != 2'b00)           req_misalign = 1'b1;
`endif
  end

  assign req_fault = req_illegal | req_misalign;

  always_comb begin
    state_d  = state_q;
    busy     = (state_q != StIdle);
    done     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_fault)           state_d = StDone;
          else if (is_load)        state_d = StLoad;
          else if (funct3 == F3_W) state_d = StWrite;
          else                     state_d = StRmwRd;
        end
      end
      StLoad: begin
        MemRead = 1'b1;
        state_d = StDone;
      end
      StRmwRd: begin
        MemRead = 1'b1;
        state_d = StWrite;
      end
      StWrite: begin
        MemWrite = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  lsu_align u_align (
    .rdata    (mem_rdata),
    .wdata    (sdata_q),
    .offset   (off_q),
    .funct3   (f3_q),
    .load_val (extract_val),
    .merged   (merge_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      sdata_q     <= '0;
      wbuf_q      <= '0;
      load_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= addr & ADDR_W'(WORD_ADDR_MASK);
        off_q   <= addr[1:0];
        f3_q    <= funct3;
        sdata_q <= store_data[15:0];
        fault_q <= req_fault;
        // A full-word store skips the read, so the buffer takes the operand directly.
        if (!is_load && funct3 == F3_W && !req_fault) wbuf_q <= store_data;
      end
      if (state_q == StLoad)  load_data_q <= extract_val;
      if (state_q == StRmwRd) wbuf_q      <= merge_val;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wbuf_q;
  assign load_data = load_data_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a word memory and a behavioural
// reference model of loads, sub-word stores, faults and latencies.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] load_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_ld;
  logic        exp_fault;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (MemWrite) mem[mem_addr[9:2]] <= mem_wdata;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .load_data  (load_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit illegal(logic ld, logic [2:0] f3);
    if (ld) return !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    return f3 > 2;
  endfunction

  function automatic bit misalign(logic [2:0] f3, logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 1 || f3 == 5) && a[0]) return 1'b1;
    if (f3 == 2 && a[1:0] != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] ext_load(logic [31:0] w, logic [2:0] f3, logic [1:0] o);
    logic [31:0] bv, hv;
    bv = (w >> (8 * int'(o))) & 32'hFF;
    hv = (w >> (16 * int'(o[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return bv[7] ? (bv | 32'hFFFF_FF00) : bv;
      3'd1:    return hv[15] ? (hv | 32'hFFFF_0000) : hv;
      3'd2:    return w;
      3'd4:    return bv;
      3'd5:    return hv;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(logic [31:0] w, logic [31:0] sd, logic [2:0] f3,
                                              logic [1:0] o);
    logic [31:0] m;
    int          sh;
    if (f3 == 0) begin m = 32'hFF;   sh = 8 * int'(o);     end
    else         begin m = 32'hFFFF; sh = 16 * int'(o[1]); end
    return (w & ~(m << sh)) | ((sd & m) << sh);
  endfunction

  // Issue one accepted request at the current negedge and check the whole transaction.
  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input bit spam);
    int          lat, elat, idx;
    logic [7:0]  rd, wr, erd, ewr;
    logic        flt_at_done;
    logic [31:0] w;
    idx = int'(a[9:2]);
    w   = ref_mem[idx];
    exp_fault = illegal(ld, f3) || misalign(f3, a);
    if (exp_fault) begin
      elat = 1; erd = 8'b0; ewr = 8'b0;
    end else if (ld) begin
      elat = 2; erd = 8'b10; ewr = 8'b0;
      exp_ld = ext_load(w, f3, a[1:0]);
    end else if (f3 == 3'd2) begin
      elat = 2; erd = 8'b0; ewr = 8'b10;
      ref_mem[idx] = sd;
    end else begin
      elat = 3; erd = 8'b10; ewr = 8'b100;
      ref_mem[idx] = merge_store(w, sd, f3, a[1:0]);
    end

    start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    @(posedge clk);
    #1;
    start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    addr = $urandom; store_data = $urandom; funct3 = 3'($urandom);
    lat = 0; rd = 8'b0; wr = 8'b0; flt_at_done = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (MemRead)  rd[c] = 1'b1;
      if (MemWrite) wr[c] = 1'b1;
      if (done) begin
        lat = c; flt_at_done = fault;
        break;
      end
      if (spam) begin start = 1'b1; is_load = 1'b1; funct3 = 3'd2; end
    end
    @(posedge clk);
    #1;
    start = 1'b0; is_load = 1'b0;
    @(negedge clk);
    check("latency",   32'(lat), 32'(elat));
    check("memread",   {24'b0, rd}, {24'b0, erd});
    check("memwrite",  {24'b0, wr}, {24'b0, ewr});
    check("fault",     {31'b0, flt_at_done}, {31'b0, exp_fault});
    check("load_data", load_data, exp_ld);
    check("idle_busy", {31'b0, busy}, 32'b0);
    check("mem_word",  mem[idx], ref_mem[idx]);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'd0; addr = 32'h0; store_data = 32'h0;
    exp_ld = 32'h0; exp_fault = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[32'h40] = 32'h8877_6655;
    ref_mem[32'h40] = 32'h8877_6655;

    #1 reset = 1'b1;
    #2;
    check("rst_busy",      {31'b0, busy},     32'b0);
    check("rst_done",      {31'b0, done},     32'b0);
    check("rst_memread",   {31'b0, MemRead},  32'b0);
    check("rst_memwrite",  {31'b0, MemWrite}, 32'b0);
    check("rst_fault",     {31'b0, fault},    32'b0);
    check("rst_load_data", load_data,         32'h0);
    check("rst_mem_addr",  mem_addr,          32'h0);
    check("rst_mem_wdata", mem_wdata,         32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_op(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 1'b0);
    check("lb_value", load_data, 32'hFFFF_FF88);
    do_op(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 1'b0);
    check("lhu_value", load_data, 32'h0000_8877);
    do_op(1'b1, 1'b0, 3'd1, 32'h100, 32'h0, 1'b0);
    check("lh_value", load_data, 32'h0000_6655);

    do_op(1'b0, 1'b1, 3'd0, 32'h101, 32'h0000_00AB, 1'b0);
    check("sb_word", mem[32'h40], 32'h8877_AB55);

    do_op(1'b0, 1'b1, 3'd1, 32'h101, 32'h0000_1234, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("sh_mis_word", mem[32'h40], 32'h8877_AB55);
    check("sh_mis_fault", {31'b0, fault}, 32'h1);
`else
    check("sh_mis_word", mem[32'h40], 32'h8877_1234);
`endif

    // Reset asserted while the sb is in its read cycle.
    mem[32'h40] = 32'h8877_6655;
    ref_mem[32'h40] = 32'h8877_6655;
    start = 1'b1; is_store = 1'b1; funct3 = 3'd0; addr = 32'h100; store_data = 32'h0000_00CD;
    @(posedge clk);
    #1;
    start = 1'b0; is_store = 1'b0;
    check("rmw_rd_memread", {31'b0, MemRead}, 32'h1);
    reset = 1'b1;
    #1;
    check("midrst_busy",      {31'b0, busy},     32'b0);
    check("midrst_memwrite",  {31'b0, MemWrite}, 32'b0);
    check("midrst_memread",   {31'b0, MemRead},  32'b0);
    check("midrst_done",      {31'b0, done},     32'b0);
    check("midrst_fault",     {31'b0, fault},    32'b0);
    check("midrst_load_data", load_data,         32'h0);
    check("midrst_mem_addr",  mem_addr,          32'h0);
    check("midrst_mem_wdata", mem_wdata,         32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_ld = 32'h0;
    check("midrst_word", mem[32'h40], 32'h8877_6655);

    // start held high through busy and DONE must not launch another access.
    do_op(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 1'b1);
    check("lw_value", load_data, 32'h8877_6655);

    do_op(1'b1, 1'b0, 3'd3, 32'h100, 32'h0, 1'b0);
    check("illegal_keep_ld", load_data, 32'h8877_6655);

    start = 1'b1; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd2;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("nokind_busy", {31'b0, busy}, 32'b0);
    check("nokind_memread", {31'b0, MemRead}, 32'b0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] kind;
      kind = 2'($urandom_range(1, 3));
      do_op(kind[0], kind[1], 3'($urandom_range(0, 7)), 32'h100 + $urandom_range(0, 15),
            $urandom, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port: sits between the execute stage and `data_memory`, turning core load/store requests into word-aligned MemRead/MemWrite cycles. Performs byte/halfword extraction with sign/zero extension for loads, and read-modify-write merging for sub-word stores, because the memory is word-only. A small Moore FSM sequences each access and reports completion with a one-cycle `done` pulse.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: data width; fixed at 32, the parameter exists for documentation only.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request strobe, sampled only in IDLE.
- `is_load`  in  1  request is a load; takes priority over `is_store`.
- `is_store`  in  1  request is a store.
- `funct3`  in  3  RV32I width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `addr`  in  32  byte address.
- `store_data`  in  32  store operand, low bytes used for sb/sh.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  last request was illegal or misaligned; valid when `done`=1, held until the next accepted start.
- `load_data`  out  32  extended load result, held until the next accepted load.
- `MemRead`  out  1  to `data_memory`.
- `MemWrite`  out  1  to `data_memory`.
- `mem_addr`  out  32  word-aligned address: `{addr[31:2],2'b00}` latched.
- `mem_wdata`  out  32  merged write word.
- `mem_rdata`  in  32  combinational read data from memory.

## Operation
- States: IDLE, LOAD, RMW_RD, WRITE, DONE.
- IDLE: on `start` with `is_load` or `is_store` set, latch addr/funct3/store_data/kind. If neither is set, ignore `start`.
  - Illegal or misaligned request -> DONE with fault=1; no memory access.
  - Load -> LOAD.
  - sw -> WRITE with `mem_wdata`=store_data.
  - sb/sh -> RMW_RD.
- Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
- LOAD: MemRead=1. At the clock edge, register the lane selected by addr[1:0] into `load_data`: sign-extended for b/h, zero-extended for bu/hu. Then -> DONE.
- RMW_RD: MemRead=1. At the clock edge, register into the write buffer: `mem_rdata` with the addressed byte (sb) or halfword (sh) lanes replaced from store_data. Then -> WRITE.
- WRITE: MemWrite=1, `mem_wdata`=write buffer. Then -> DONE.
- DONE: done=1. Then -> IDLE.
- `start` outside IDLE is ignored; there is no queueing.
- Memory-side outputs are a function of state and latched registers only, never of live core inputs.
- Reset values: state IDLE; `load_data`, `fault`, `mem_addr`, `mem_wdata` and the write buffer are 0; `done`, `busy`, `MemRead`, `MemWrite` are 0.
- Reset mid-operation forces IDLE immediately and drops MemWrite. An interrupted RMW never writes, so memory is unchanged.

## Timing
- Start accepted at edge N. Latency to `done`:
  - load: done in cycle N+2.
  - sw: done in cycle N+2.
  - sb/sh: done in cycle N+3.
  - fault: done in cycle N+1.
- MemWrite is high for exactly one cycle per store. Memory commits on the edge that leaves WRITE.
- Earliest next accept is the edge ending the first IDLE cycle after DONE.
- Memory read is combinational; the LOAD/RMW_RD sample is taken at the end of that single cycle.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Halfword accesses with addr[0]=1 set fault.
  - Word accesses with addr[1:0]!=0 set fault.
- Undefined:
  - Misaligned low address bits are masked to natural alignment (h: addr[0] ignored; w: addr[1:0] ignored) and the access proceeds.
  - Only illegal funct3 sets fault.

## Structure
- Package `lsu_pkg`: the state enum, funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), and the word-address mask.
- Sub-module `lsu_align`, combinational, contains two functions:
  - Lane extract/extend: inputs rdata, offset, funct3; output load value.
  - Lane merge: inputs rdata, wdata, offset, funct3; output merged word.
- The FSM and all registers stay in `load_store_unit`.

## Test plan
All scenarios preload memory word 0x100 = 0x88776655.
- lb addr 0x103 -> load_data=0xFFFFFF88, done in cycle N+2, fault=0, MemWrite never high.
- lhu addr 0x102 -> load_data=0x00008877; lh addr 0x100 -> 0x00006655.
- sb addr 0x101, store_data 0x000000AB -> word 0x100 becomes 0x8877AB55; MemRead only in N+1, MemWrite only in N+2, done in N+3.
- sh addr 0x101:
  - With `LSU_MISALIGN_TRAP_EN`: fault=1 and done in N+1, no MemRead/MemWrite, memory unchanged.
  - Without it: halfword lanes 1:0 written.
- Assert reset during RMW_RD of sb 0x100 -> busy=0 and MemWrite=0 immediately, word stays 0x88776655, all outputs at reset values.
- `start` pulsed during busy and during DONE -> ignored. Illegal funct3=011 load -> fault=1 in N+1, load_data keeps its previous value.
